// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes a MIPS instruction into ALU operands
// and registers them for the execute stage.
module alu_issue_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        stall,
  input  logic        flush,
  output logic        in_ready,
  output logic        out_valid,
  output logic [3:0]  alu_cnt,
  output logic [31:0] input1,
  output logic [31:0] input2,
  output logic [4:0]  shamt,
  output logic [4:0]  dest_reg,
  output logic        reg_write,
  output logic        illegal,
  output logic [15:0] issue_count
);

  typedef struct packed {
    logic [3:0]  cnt;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  sh;
    logic [4:0]  dest;
    logic        wr;
    logic        ill;
  } dec_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_NOT = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] sext;
  logic [31:0] zext;
  logic        ok;
  dec_t        d;
  logic        unused_rs_idx;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign sext          = {{16{instr[15]}}, instr[15:0]};
  assign zext          = {16'b0, instr[15:0]};
  assign unused_rs_idx = ^instr[25:21];
  assign in_ready      = !stall;

  always_comb begin
    d  = '0;
    ok = 1'b1;
    unique case (opcode)
      6'h00: begin
        d.dest = instr[15:11];
        d.wr   = 1'b1;
        d.in1  = rs_data;
        d.in2  = rt_data;
        unique case (funct)
          6'h20: d.cnt = ALU_ADD;
          6'h22: d.cnt = ALU_SUB;
          6'h27: d.cnt = ALU_NOT;
          6'h24: d.cnt = ALU_AND;
          6'h25: d.cnt = ALU_OR;
          6'h2A: d.cnt = ALU_SLT;
          6'h00, 6'h02: begin
            d.cnt = (funct == 6'h00) ? ALU_SLL : ALU_SRL;
            d.in1 = rt_data;
            d.in2 = '0;
            d.sh  = instr[10:6];
          end
          default: ok = 1'b0;
        endcase
      end
      6'h08, 6'h23: begin
        d.cnt = ALU_ADD;
        d.in2 = sext;
        d.wr  = 1'b1;
      end
      6'h2B: begin
        d.cnt = ALU_ADD;
        d.in2 = sext;
      end
      6'h0A: begin
        d.cnt = ALU_SLT;
        d.in2 = sext;
        d.wr  = 1'b1;
      end
      6'h0C: begin
        d.cnt = ALU_AND;
        d.in2 = zext;
        d.wr  = 1'b1;
      end
      6'h0D: begin
        d.cnt = ALU_OR;
        d.in2 = zext;
        d.wr  = 1'b1;
      end
      6'h04: begin
        d.cnt = ALU_SUB;
        d.in2 = rt_data;
      end
      default: ok = 1'b0;
    endcase
    if (opcode != 6'h00) begin
      d.in1  = rs_data;
      d.dest = instr[20:16];
    end
    // Unsupported encodings still issue, but carry no operands.
    if (!ok) begin
      d     = '0;
      d.ill = 1'b1;
    end
    if (!in_valid) d = '0;
    if (d.dest == 5'd0) d.wr = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      alu_cnt     <= '0;
      input1      <= '0;
      input2      <= '0;
      shamt       <= '0;
      dest_reg    <= '0;
      reg_write   <= 1'b0;
      illegal     <= 1'b0;
      issue_count <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      alu_cnt     <= '0;
      input1      <= '0;
      input2      <= '0;
      shamt       <= '0;
      dest_reg    <= '0;
      reg_write   <= 1'b0;
      illegal     <= 1'b0;
    end else if (!stall) begin
      out_valid   <= in_valid;
      alu_cnt     <= d.cnt;
      input1      <= d.in1;
      input2      <= d.in2;
      shamt       <= d.sh;
      dest_reg    <= d.dest;
      reg_write   <= d.wr;
      illegal     <= d.ill;
      issue_count <= issue_count + 16'(in_valid);
    end
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk, reset.
REQ-002 The port list SHALL be, in order:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  instr/rs_data/rt_data valid this cycle
- instr  in  32  MIPS instruction word
- rs_data  in  32  register-file read of instr[25:21]
- rt_data  in  32  register-file read of instr[20:16]
- stall  in  1  hold pipeline register contents
- flush  in  1  replace pipeline register contents with bubble
- in_ready  out  1  equals !stall
- out_valid  out  1  registered ALU operands valid
- alu_cnt  out  4  ALU operation code
- input1  out  32  ALU operand 1
- input2  out  32  ALU operand 2
- shamt  out  5  shift amount
- dest_reg  out  5  writeback register index
- reg_write  out  1  writeback enable
- illegal  out  1  unsupported instruction issued
- issue_count  out  16  count of valid instructions issued
REQ-003 All outputs except in_ready SHALL be registered.

Function
REQ-004 ALU codes SHALL be: 0000 add, 0001 sub, 0010 not(input1), 0011 sll input1 by shamt, 0100 srl input1 by shamt, 0101 and, 0110 or, 0111 slt.
REQ-005 For opcode 0x00, decode by funct: 0x20->0000, 0x22->0001, 0x27->0010, 0x00->0011, 0x02->0100, 0x24->0101, 0x25->0110, 0x2A->0111; dest_reg=instr[15:11], reg_write=1.
REQ-006 R-type operands: input1=rs_data, input2=rt_data, shamt=0; sll/srl use input1=rt_data, input2=0, shamt=instr[10:6].
REQ-007 I-type decode: addi 0x08->0000 sign-ext; slti 0x0A->0111 sign-ext; andi 0x0C->0101 zero-ext; ori 0x0D->0110 zero-ext; lw 0x23->0000 sign-ext; sw 0x2B->0000 sign-ext, reg_write=0; beq 0x04->0001 with input2=rt_data, reg_write=0.
REQ-008 I-type: input1=rs_data, input2=extended instr[15:0] (except beq), shamt=0, dest_reg=instr[20:16].
REQ-009 Any other opcode/funct SHALL issue with illegal=1, alu_cnt=0000, input1=input2=0, shamt=0, dest_reg=0, reg_write=0.
REQ-010 Latency SHALL be one cycle: inputs accepted at edge N appear on outputs after edge N.
REQ-011 Update priority per edge: reset > flush > stall > load.
REQ-012 Load (no flush, no stall): out_valid<=in_valid; decoded fields loaded; if in_valid=0 all data outputs loaded as bubble (zero, reg_write=0, illegal=0).
REQ-013 Stall (no flush): every registered output SHALL hold its value; issue_count SHALL hold.
REQ-014 Flush (with or without stall): registers SHALL load a bubble (out_valid=0, reg_write=0, illegal=0, data fields 0); the input this cycle SHALL be dropped.
REQ-015 issue_count SHALL increment by 1 on each load with in_valid=1, including illegal instructions, and wrap 0xFFFF->0x0000.
REQ-016 reg_write SHALL be 0 whenever dest_reg=0.

Reset
REQ-017 Synchronous reset SHALL set out_valid, alu_cnt, input1, input2, shamt, dest_reg, reg_write, illegal and issue_count to 0.
REQ-018 Reset asserted with stall or flush SHALL still clear all registers; in_ready SHALL follow !stall during reset.
REQ-019 Reset mid-stream SHALL drop the current input and resume accepting on the first edge after deassertion.

Verification
REQ-020 add $3,$1,$2 (0x00221820), rs=4, rt=2 -> next cycle out_valid=1, alu_cnt=0000, input1=4, input2=2, dest_reg=3, reg_write=1, issue_count=1.
REQ-021 sll $4,$2,3 (0x000220C0), rt=4 -> alu_cnt=0011, input1=4, input2=0, shamt=3, dest_reg=4.
REQ-022 addi $5,$1,-1 (0x2025FFFF), rs=4 -> alu_cnt=0000, input2=0xFFFFFFFF; ori $5,$1,0xFFFF (0x3425FFFF) -> alu_cnt=0110, input2=0x0000FFFF.
REQ-023 Load valid instr, then stall=1 for 3 cycles with new instr on inputs -> outputs and issue_count unchanged for 3 cycles, in_ready=0; flush=1 with stall=1 -> out_valid=0 next cycle.
REQ-024 Opcode 0x3F with in_valid=1 -> illegal=1, reg_write=0, alu_cnt=0000, issue_count increments; preset issue_count to 0xFFFF via 65535 issues, one more -> 0x0000.
REQ-025 Reset asserted one cycle during a valid stream -> all outputs 0 after that edge; first post-reset instruction appears one cycle after acceptance.
